// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: accepts a qualified trap at the next instruction
// boundary, vectors into the handler jump table, and returns on mret.
`ifndef NMI
`define NMI    3'd1
`endif
`ifndef EBREAK
`define EBREAK 3'd2
`endif
`ifndef TMR
`define TMR    3'd3
`endif
`ifndef INT
`define INT    3'd4
`endif
`ifndef ECALL
`define ECALL  3'd5
`endif

module interrupt_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interFlag,
  input  logic [2:0]  interSel,
  input  logic [31:0] pc_current,
  input  logic        instr_boundary,
  input  logic        mret,
  input  logic        inter_en_wr,
  input  logic        inter_en_wdata,
  output logic        en_inter,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        ack,
  output logic [31:0] epc,
  output logic [2:0]  cause,
  output logic        in_handler
);

  typedef enum logic [1:0] {IDLE, WAIT, VECTOR, HANDLER} state_t;

  state_t      state;
  logic        prev_en;
  logic [2:0]  wait_cause;
  logic [31:0] vec_target;

  // An NMI seen on the boundary cycle itself must still steer the vector.
  assign wait_cause = (interFlag && (interSel == `NMI)) ? `NMI : cause;
  assign vec_target = VEC_BASE + {27'b0, wait_cause, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      en_inter    <= 1'b1;
      prev_en     <= 1'b1;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'h0;
      ack         <= 1'b0;
      epc         <= 32'h0;
      cause       <= `ECALL;
      in_handler  <= 1'b0;
    end else begin
      redirect <= 1'b0;
      ack      <= 1'b0;
      case (state)
        IDLE: begin
          if (inter_en_wr) en_inter <= inter_en_wdata;
          // The mret return pulse cycle is IDLE but must not start a new entry.
          if (interFlag && !redirect) begin
            cause <= interSel;
            stall <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          cause <= wait_cause;
          if (instr_boundary) begin
            epc         <= pc_current;
            redirect    <= 1'b1;
            ack         <= 1'b1;
            redirect_pc <= vec_target;
            prev_en     <= en_inter;
            en_inter    <= 1'b0;
            state       <= VECTOR;
          end
        end
        VECTOR: begin
          stall      <= 1'b0;
          in_handler <= 1'b1;
          state      <= HANDLER;
        end
        HANDLER: begin
          // Return restore takes priority over a same-cycle software write.
          if (mret) begin
            redirect    <= 1'b1;
            redirect_pc <= epc;
            en_inter    <= prev_en;
            in_handler  <= 1'b0;
            state       <= IDLE;
          end else if (inter_en_wr) begin
            en_inter <= inter_en_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed, table-driven bench for interrupt_sequencer with hand-written
// sequences for async reset and boundary-latency corners.
`ifndef NMI
`define NMI    3'd1
`endif
`ifndef EBREAK
`define EBREAK 3'd2
`endif
`ifndef TMR
`define TMR    3'd3
`endif
`ifndef INT
`define INT    3'd4
`endif
`ifndef ECALL
`define ECALL  3'd5
`endif

module tb_interrupt_sequencer;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        interFlag, instr_boundary, mret, inter_en_wr, inter_en_wdata;
  logic [2:0]  interSel;
  logic [31:0] pc_current;
  logic        en_inter, stall, redirect, ack, in_handler;
  logic [31:0] redirect_pc, epc;
  logic [2:0]  cause;

  always #5 clk = ~clk;

  interrupt_sequencer #(.VEC_BASE(VEC_BASE)) dut (
    .clk(clk), .rst(rst), .interFlag(interFlag), .interSel(interSel),
    .pc_current(pc_current), .instr_boundary(instr_boundary), .mret(mret),
    .inter_en_wr(inter_en_wr), .inter_en_wdata(inter_en_wdata),
    .en_inter(en_inter), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ack(ack), .epc(epc), .cause(cause),
    .in_handler(in_handler)
  );

  typedef struct packed {
    logic        en;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        in_h;
  } outs_t;

  typedef struct {
    logic        flag;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic        bnd;
    logic        mr;
    logic        wr;
    logic        wd;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] tgt(input logic [2:0] c);
    return VEC_BASE + 32'(c) * 32'd4;
  endfunction

  function automatic outs_t o(input logic en, input logic st, input logic rd,
                              input logic [31:0] rpc, input logic ak,
                              input logic [31:0] ep, input logic [2:0] ca,
                              input logic ih);
    return {en, st, rd, rpc, ak, ep, ca, ih};
  endfunction

  function automatic outs_t actual();
    return {en_inter, stall, redirect, redirect_pc, ack, epc, cause, in_handler};
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got en=%b stall=%b redir=%b rpc=%h ack=%b epc=%h cause=%0d inh=%b want en=%b stall=%b redir=%b rpc=%h ack=%b epc=%h cause=%0d inh=%b",
               name, a.en, a.stall, a.redirect, a.rpc, a.ack, a.epc, a.cause, a.in_h,
               e.en, e.stall, e.redirect, e.rpc, e.ack, e.epc, e.cause, e.in_h);
    end
  endtask

  task automatic add(input logic flag, input logic [2:0] sel, input logic [31:0] pc,
                     input logic bnd, input logic mr, input logic wr, input logic wd,
                     input outs_t e);
    vec_t t;
    t.flag = flag; t.sel = sel; t.pc = pc; t.bnd = bnd;
    t.mr = mr; t.wr = wr; t.wd = wd; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic flag, input logic [2:0] sel, input logic [31:0] pc,
                       input logic bnd, input logic mr, input logic wr, input logic wd);
    interFlag = flag; interSel = sel; pc_current = pc; instr_boundary = bnd;
    mret = mr; inter_en_wr = wr; inter_en_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t rst_o;
    int    n;
    bit    seen;
    rst_o = o(1, 0, 0, 32'h0, 0, 32'h0, `ECALL, 0);

    // Timer entry, masked NMI in handler, return with same-cycle write
    add(1, `TMR, 32'h2000, 1, 0, 0, 0, o(1, 1, 0, 32'h0, 0, 32'h0, `TMR, 0));
    add(1, `TMR, 32'h2000, 1, 0, 0, 0, o(0, 1, 1, tgt(`TMR), 1, 32'h2000, `TMR, 0));
    add(0, `TMR, 32'h2000, 0, 0, 0, 0, o(0, 0, 0, tgt(`TMR), 0, 32'h2000, `TMR, 1));
    add(1, `NMI, 32'h3000, 1, 0, 0, 0, o(0, 0, 0, tgt(`TMR), 0, 32'h2000, `TMR, 1));
    add(0, `NMI, 32'h3000, 0, 1, 1, 0, o(1, 0, 1, 32'h2000, 0, 32'h2000, `TMR, 0));
    add(0, 3'd0, 32'h0, 0, 0, 0, 0, o(1, 0, 0, 32'h2000, 0, 32'h2000, `TMR, 0));
    // Enable writes in IDLE
    add(0, 3'd0, 32'h0, 0, 0, 1, 0, o(0, 0, 0, 32'h2000, 0, 32'h2000, `TMR, 0));
    add(0, 3'd0, 32'h0, 0, 0, 1, 1, o(1, 0, 0, 32'h2000, 0, 32'h2000, `TMR, 0));
    // INT with late boundary, NMI upgrade, dropped write in WAIT
    add(1, `INT, 32'h4000, 0, 0, 0, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `INT, 0));
    add(1, `INT, 32'h4000, 0, 0, 1, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `INT, 0));
    add(1, `NMI, 32'h4000, 0, 0, 0, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `NMI, 0));
    add(1, `EBREAK, 32'h4000, 0, 0, 0, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `NMI, 0));
    add(0, `INT, 32'h4000, 0, 0, 0, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `NMI, 0));
    add(1, `INT, 32'h4000, 0, 0, 0, 0, o(1, 1, 0, 32'h2000, 0, 32'h2000, `NMI, 0));
    add(0, `INT, 32'h4444, 1, 0, 0, 0, o(0, 1, 1, tgt(`NMI), 1, 32'h4444, `NMI, 0));
    add(0, 3'd0, 32'h0, 0, 0, 0, 0, o(0, 0, 0, tgt(`NMI), 0, 32'h4444, `NMI, 1));
    // Held request in handler, writes in handler, mret restores prev_en
    add(1, `TMR, 32'h0, 0, 0, 0, 0, o(0, 0, 0, tgt(`NMI), 0, 32'h4444, `NMI, 1));
    add(1, `TMR, 32'h0, 0, 0, 1, 1, o(1, 0, 0, tgt(`NMI), 0, 32'h4444, `NMI, 1));
    add(1, `TMR, 32'h0, 0, 0, 1, 0, o(0, 0, 0, tgt(`NMI), 0, 32'h4444, `NMI, 1));
    add(1, `TMR, 32'h0, 0, 1, 0, 0, o(1, 0, 1, 32'h4444, 0, 32'h4444, `NMI, 0));
    add(1, `TMR, 32'h5000, 1, 1, 0, 0, o(1, 0, 0, 32'h4444, 0, 32'h4444, `NMI, 0));
    add(1, `TMR, 32'h5000, 1, 0, 0, 0, o(1, 1, 0, 32'h4444, 0, 32'h4444, `TMR, 0));
    add(1, `TMR, 32'h5000, 1, 1, 0, 0, o(0, 1, 1, tgt(`TMR), 1, 32'h5000, `TMR, 0));
    add(0, 3'd0, 32'h0, 0, 1, 1, 1, o(0, 0, 0, tgt(`TMR), 0, 32'h5000, `TMR, 1));
    add(0, 3'd0, 32'h0, 0, 1, 0, 0, o(1, 0, 1, 32'h5000, 0, 32'h5000, `TMR, 0));
    add(0, 3'd0, 32'h0, 0, 0, 0, 0, o(1, 0, 0, 32'h5000, 0, 32'h5000, `TMR, 0));
    // Entry with enable already clear: return restores 0
    add(0, 3'd0, 32'h0, 0, 0, 1, 0, o(0, 0, 0, 32'h5000, 0, 32'h5000, `TMR, 0));
    add(1, `EBREAK, 32'h6000, 1, 0, 0, 0, o(0, 1, 0, 32'h5000, 0, 32'h5000, `EBREAK, 0));
    add(1, `EBREAK, 32'h6000, 1, 0, 0, 0, o(0, 1, 1, tgt(`EBREAK), 1, 32'h6000, `EBREAK, 0));
    add(0, 3'd0, 32'h0, 0, 0, 0, 0, o(0, 0, 0, tgt(`EBREAK), 0, 32'h6000, `EBREAK, 1));
    add(0, 3'd0, 32'h0, 0, 0, 1, 1, o(1, 0, 0, tgt(`EBREAK), 0, 32'h6000, `EBREAK, 1));
    add(0, 3'd0, 32'h0, 0, 1, 0, 0, o(0, 0, 1, 32'h6000, 0, 32'h6000, `EBREAK, 0));
    add(0, 3'd0, 32'h0, 0, 0, 0, 0, o(0, 0, 0, 32'h6000, 0, 32'h6000, `EBREAK, 0));
    add(0, 3'd0, 32'h0, 0, 0, 1, 1, o(1, 0, 0, 32'h6000, 0, 32'h6000, `EBREAK, 0));

    rst = 1'b0;
    drive(0, 3'd0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", rst_o);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flag, vecs[i].sel, vecs[i].pc, vecs[i].bnd,
            vecs[i].mr, vecs[i].wr, vecs[i].wd);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Long WAIT without boundary, then bounded wait for the vector pulse
    @(negedge clk) drive(1, `INT, 32'h7000, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("late_wait_entry", o(1, 1, 0, 32'h6000, 0, 32'h6000, `INT, 0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) drive(0, 3'd0, 32'h7000, 0, 0, 0, 0);
      @(posedge clk);
      #1 check($sformatf("late_wait_hold%0d", k), o(1, 1, 0, 32'h6000, 0, 32'h6000, `INT, 0));
    end
    @(negedge clk) drive(0, 3'd0, 32'h7100, 1, 0, 0, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4) begin
      @(posedge clk);
      #1 n++;
      seen = redirect;
    end
    checks++;
    if (!seen || n != 1) begin
      errors++;
      $display("FAIL boundary_latency got seen=%0b cycles=%0d want seen=1 cycles=1", seen, n);
    end
    check("late_vector", o(0, 1, 1, tgt(`INT), 1, 32'h7100, `INT, 0));
    @(negedge clk) drive(0, 3'd0, 32'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("late_handler", o(0, 0, 0, tgt(`INT), 0, 32'h7100, `INT, 1));
    @(negedge clk) drive(0, 3'd0, 32'h0, 0, 1, 0, 0);
    @(posedge clk);
    #1 check("late_return", o(1, 0, 1, 32'h7100, 0, 32'h7100, `INT, 0));
    @(negedge clk) drive(0, 3'd0, 32'h0, 0, 0, 0, 0);
    @(posedge clk);

    // Asynchronous reset in the middle of WAIT
    @(negedge clk) drive(1, `TMR, 32'h7777, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("wait_before_reset", o(1, 1, 0, 32'h7100, 0, 32'h7100, `TMR, 0));
    #2 rst = 1'b0;
    #1 check("async_reset_mid_wait", rst_o);
    @(negedge clk) drive(0, 3'd0, 32'h7777, 1, 0, 0, 0);
    @(posedge clk);
    #1 check("reset_held", rst_o);
    @(negedge clk);
    rst = 1'b1;
    drive(1, `TMR, 32'h8000, 1, 0, 0, 0);
    @(posedge clk);
    #1 check("first_trap_after_reset", o(1, 1, 0, 32'h0, 0, 32'h0, `TMR, 0));
    @(posedge clk);
    #1 check("first_vector_after_reset", o(0, 1, 1, tgt(`TMR), 1, 32'h8000, `TMR, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
